hilo_divider: RTL and testbench
===============================

# hilo_divider

Multi-cycle 32-bit integer divider in the EX stage that produces the quotient and remainder for DIV/DIVU and writes them into the HI/LO register pair. It is the write-side partner of the HI/LO register: it drives the HI/LO write-enable and data buses, and it stalls the pipeline while an iterative radix-2 division runs. It accepts an operand pair, iterates one quotient bit per cycle, and presents a one-cycle write strobe with HI = remainder and LO = quotient.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; low forces reset state immediately.
- start  input  1  request a division; sampled only in IDLE.
- signed_op  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  DATA_WIDTH  operand rs; captured when start is accepted.
- divisor  input  DATA_WIDTH  operand rt; captured when start is accepted.
- cancel  input  1  pipeline flush; aborts the operation in progress.
- stall_request  output  1  hold the pipeline while the divider is occupied.
- write_enable  output  1  one-cycle HI/LO write strobe.
- hi_input  output  DATA_WIDTH  remainder, valid while write_enable = 1.
- lo_input  output  DATA_WIDTH  quotient, valid while write_enable = 1.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if start = 1 and cancel = 0, the rising edge does the following.
  - Captures the operand magnitudes. In signed mode each negative operand is negated; otherwise operands are taken as-is.
  - Latches signed_op, the dividend sign, and the sign-differ flag.
  - Clears the iteration counter and the partial remainder.
  - If divisor = 0, goes directly to DONE. Otherwise goes to BUSY.
- BUSY: restoring step each cycle on a (DATA_WIDTH+1)-bit partial remainder.
  - Shift {remainder, quotient} left by 1, bringing in the next dividend MSB.
  - Compute trial = remainder − divisor. If trial ≥ 0, keep trial and set the quotient LSB to 1; otherwise restore and set it to 0.
  - After DATA_WIDTH steps, go to DONE.
- DONE, lasting one cycle:
  - write_enable = 1.
  - lo_input = quotient, negated if signed and the operand signs differ.
  - hi_input = remainder, negated if signed and the dividend was negative. The remainder sign follows the dividend.
  - The next state is always IDLE.
- Divide by zero, both modes: lo_input = all ones and hi_input = the original dividend, unmodified.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo_input = 0x80000000, hi_input = 0. This falls out of the magnitude path and needs no special case.
- Arithmetic is modulo 2^DATA_WIDTH. The comparison uses DATA_WIDTH+1 bits, so a divisor of 0x80000000 or larger is handled unsigned-correctly.
- cancel = 1 in BUSY or DONE: the next state is IDLE and no write occurs. In DONE, cancel also gates write_enable to 0 combinationally.
- start while BUSY or DONE is ignored and not queued.
- stall_request = (state == IDLE && start && !cancel) || state == BUSY. It is 0 in DONE, so the instruction advances on the same edge that HI/LO is written.
- hi_input and lo_input are registered and hold their last values outside DONE. The HI/LO register samples them only when write_enable = 1.

## Timing
- Reset (reset = 0, asynchronous), taking effect immediately, independent of clock:
  - state = IDLE; write_enable = 0; stall_request = 0.
  - hi_input = 0; lo_input = 0.
  - Counter and partial remainder = 0.
- Reset mid-operation aborts the division with no write. Deassertion is synchronised externally; the first edge with reset = 1 may accept start.
- Start accepted at edge E0, where cycle 0 is the start cycle.
  - BUSY during cycles 1..DATA_WIDTH (32 cycles).
  - DONE in cycle 33, with write_enable = 1 for exactly one cycle.
  - IDLE in cycle 34. A new start may be sampled in cycle 34.
- Divide by zero: DONE in cycle 1, latency 1.
- stall_request is high in cycles 0..32 and low in cycle 33.
- Back-to-back operation: the minimum issue interval is DATA_WIDTH+2 cycles.
- Simultaneous start and cancel in IDLE: start is ignored.

## Test plan
- Unsigned divide: DIVU with 100 / 7, start at cycle 0.
  - Cycle 33: write_enable = 1, lo_input = 14, hi_input = 2.
  - stall_request is high in cycles 0..32 and low in cycle 33.
- Signed divide, negative dividend: DIV with 0xFFFFFFF9 (−7) / 2.
  - Required: lo_input = 0xFFFFFFFD, hi_input = 0xFFFFFFFF.
  - Also run 7 / −2. Required: lo_input = 0xFFFFFFFD, hi_input = 1.
- Boundary operands:
  - DIV 0x80000000 / 0xFFFFFFFF: lo_input = 0x80000000, hi_input = 0.
  - DIVU 0xFFFFFFFF / 0x80000000: lo_input = 1, hi_input = 0x7FFFFFFF.
- Divide by zero: DIVU 0x12345678 / 0.
  - Cycle 1: write_enable = 1, lo_input = 0xFFFFFFFF, hi_input = 0x12345678.
  - Cycle 2: IDLE.
- Cancel and restart:
  - cancel at cycle 10 of a busy division: IDLE next cycle, write_enable never rises, stall_request = 0.
  - Then start 9 / 3: lo_input = 3, hi_input = 0 exactly 33 cycles later.
- Reset and ignored start:
  - reset = 0 asserted between edges at cycle 20 of a busy division: all outputs go to 0 immediately, with no write.
  - A start pulsed during BUSY is ignored: exactly one write_enable pulse per accepted start.

Source files
------------

// File: rtl/hilo_divider_if.sv
// Operand/result bundle between the EX-stage divider and its
// pipeline-control and HI/LO register neighbours.
interface hilo_divider_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  signed_op;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  cancel;
   logic                  stall_request;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] hi_input;
   logic [DATA_WIDTH-1:0] lo_input;

   modport master (
      output start, signed_op, dividend, divisor, cancel,
      input  stall_request, write_enable, hi_input, lo_input
   );

   modport slave (
      input  start, signed_op, dividend, divisor, cancel,
      output stall_request, write_enable, hi_input, lo_input
   );
endinterface

// File: rtl/hilo_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Writes remainder to HI and quotient to LO via a one-cycle strobe.
module hilo_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic           clock,
   input  logic           reset,
   hilo_divider_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [W:0]    rem;
   logic [W-1:0]  quot;
   logic [W-1:0]  dvsr;
   logic          sgn;
   logic          neg_dvd;
   logic          differ;
   logic          done_q;
   logic [W-1:0]  hi_q;
   logic [W-1:0]  lo_q;

   logic          a_neg;
   logic          b_neg;
   logic [W-1:0]  a_mag;
   logic [W-1:0]  b_mag;
   logic          accept;
   logic [W:0]    shifted;
   logic [W:0]    trial;
   logic [W:0]    rem_nxt;
   logic [W-1:0]  quot_nxt;

   assign a_neg  = bus.signed_op & bus.dividend[W-1];
   assign b_neg  = bus.signed_op & bus.divisor[W-1];
   assign a_mag  = a_neg ? -bus.dividend : bus.dividend;
   assign b_mag  = b_neg ? -bus.divisor : bus.divisor;
   assign accept = (state == IDLE) & bus.start & ~bus.cancel;

   // Remainder stays below the divisor, so W+1 bits hold 2*rem+1
   // and trial[W] is a true sign bit.
   assign shifted  = {rem[W-1:0], quot[W-1]};
   assign trial    = shifted - {1'b0, dvsr};
   assign rem_nxt  = trial[W] ? shifted : trial;
   assign quot_nxt = {quot[W-2:0], ~trial[W]};

   assign bus.stall_request = reset & (accept | (state == BUSY));
   assign bus.write_enable  = done_q & ~bus.cancel;
   assign bus.hi_input      = hi_q;
   assign bus.lo_input      = lo_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         rem     <= '0;
         quot    <= '0;
         dvsr    <= '0;
         sgn     <= 1'b0;
         neg_dvd <= 1'b0;
         differ  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  quot    <= a_mag;
                  dvsr    <= b_mag;
                  sgn     <= bus.signed_op;
                  neg_dvd <= a_neg;
                  differ  <= a_neg ^ b_neg;
                  count   <= '0;
                  rem     <= '0;
                  if (bus.divisor == '0) begin
                     hi_q   <= bus.dividend;
                     lo_q   <= '1;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state  <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (bus.cancel) begin
                  state <= IDLE;
               end else begin
                  rem   <= rem_nxt;
                  quot  <= quot_nxt;
                  count <= count + 1'b1;
                  if (count == CW'(W - 1)) begin
                     lo_q   <= (sgn & differ) ? -quot_nxt : quot_nxt;
                     hi_q   <= (sgn & neg_dvd) ? -rem_nxt[W-1:0]
                                               : rem_nxt[W-1:0];
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: vector table with a
// scoreboard queue plus hand-written cancel/reset/ignore sequences.
module tb_hilo_divider;
   localparam int W = 32;

   typedef struct {
      logic          sop;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  lo;
      logic [W-1:0]  hi;
      int            lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   nwr;
   exp_t sb[$];
   vec_t tv[$];

   hilo_divider_if #(.DATA_WIDTH(W)) bus ();

   hilo_divider #(.DATA_WIDTH(W)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.write_enable === 1'b1) begin
         exp_t e;
         nwr++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_write: lo %h hi %h", bus.lo_input,
                     bus.hi_input);
         end else begin
            e = sb.pop_front();
            chk("lo", bus.lo_input, e.lo);
            chk("hi", bus.hi_input, e.hi);
         end
      end
   end

   task automatic drive(input logic sop, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      bus.signed_op = sop;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.start     = 1'b1;
   endtask

   task automatic run_op(input vec_t v);
      exp_t e;
      bit   seen;
      @(negedge clk);
      #1;
      drive(v.sop, v.a, v.b);
      e.lo = v.lo;
      e.hi = v.hi;
      sb.push_back(e);
      #1;
      chk("stall_c0", W'(bus.stall_request), W'(1));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      seen = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (bus.write_enable === 1'b1) begin
            seen = 1;
            chk("latency", W'(c), W'(v.lat));
            chk("stall_done", W'(bus.stall_request), W'(0));
         end else if (c <= v.lat) begin
            chk("stall_busy", W'(bus.stall_request), W'(1));
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL timeout: no write got 0 want 1");
         void'(sb.pop_back());
      end
      @(negedge clk);
      chk("we_idle", W'(bus.write_enable), W'(0));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int   w0;
      vec_t v;
      total = 0;
      bad   = 0;
      nwr   = 0;
      rst_n = 1'b0;
      bus.start     = 1'b0;
      bus.cancel    = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;

      tv.push_back('{0, 32'd100,        32'd7,        32'd14,       32'd2,        33});
      tv.push_back('{1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33});
      tv.push_back('{1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33});
      tv.push_back('{1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        33});
      tv.push_back('{0, 32'hFFFFFFFF,   32'h80000000, 32'd1,        32'h7FFFFFFF, 33});
      tv.push_back('{0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, 1});
      tv.push_back('{1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1});
      tv.push_back('{1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 33});
      tv.push_back('{0, 32'hDEADBEEF,   32'h10,       32'h0DEADBEE, 32'hF,        33});
      tv.push_back('{1, 32'hDEADBEEF,   32'h10,       32'hFDEADBEF, 32'hFFFFFFFF, 33});
      tv.push_back('{0, 32'd5,          32'd9,        32'd0,        32'd5,        33});
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = $urandom_range(1, 32'hFFFF);
         tv.push_back('{0, a, b, a / b, a % b, 33});
      end

      #12;
      chk("rst_we", W'(bus.write_enable), W'(0));
      chk("rst_stall", W'(bus.stall_request), W'(0));
      chk("rst_hi", bus.hi_input, 32'd0);
      chk("rst_lo", bus.lo_input, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tv[i]) run_op(tv[i]);

      // start together with cancel in IDLE must not launch
      @(negedge clk);
      #1;
      drive(0, 32'd50, 32'd5);
      bus.cancel = 1'b1;
      #1;
      chk("sc_stall", W'(bus.stall_request), W'(0));
      @(negedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      w0 = nwr;
      idle_cycles(40);
      chk("sc_nowrite", W'(nwr - w0), W'(0));

      // cancel at cycle 10 of a busy division
      @(negedge clk);
      #1;
      drive(0, 32'd1000, 32'd3);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      idle_cycles(9);
      #1;
      bus.cancel = 1'b1;
      @(negedge clk);
      chk("cx_stall", W'(bus.stall_request), W'(0));
      chk("cx_we", W'(bus.write_enable), W'(0));
      #1;
      bus.cancel = 1'b0;
      w0 = nwr;
      idle_cycles(40);
      chk("cx_nowrite", W'(nwr - w0), W'(0));
      v = '{0, 32'd9, 32'd3, 32'd3, 32'd0, 33};
      run_op(v);

      // cancel during DONE gates the strobe
      @(negedge clk);
      #1;
      drive(0, 32'h55, 32'd0);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b1;
      @(negedge clk);
      chk("cd_we", W'(bus.write_enable), W'(0));
      chk("cd_stall", W'(bus.stall_request), W'(0));
      #1;
      bus.cancel = 1'b0;
      @(negedge clk);
      chk("cd_we2", W'(bus.write_enable), W'(0));

      // start pulsed while BUSY is ignored
      @(negedge clk);
      #1;
      drive(0, 32'd100, 32'd7);
      sb.push_back('{32'd14, 32'd2});
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      w0 = nwr;
      idle_cycles(4);
      #1;
      drive(0, 32'd1, 32'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      idle_cycles(45);
      chk("ign_writes", W'(nwr - w0), W'(1));
      chk("ign_sb", W'(sb.size()), W'(0));

      // asynchronous reset at cycle 20 of a busy division
      @(negedge clk);
      #1;
      drive(0, 32'd77777, 32'd3);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      idle_cycles(19);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_we", W'(bus.write_enable), W'(0));
      chk("ar_stall", W'(bus.stall_request), W'(0));
      chk("ar_hi", bus.hi_input, 32'd0);
      chk("ar_lo", bus.lo_input, 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      w0 = nwr;
      idle_cycles(40);
      chk("ar_nowrite", W'(nwr - w0), W'(0));
      chk("ar_stall2", W'(bus.stall_request), W'(0));
      v = '{1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
      run_op(v);

      chk("sb_empty", W'(sb.size()), W'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
